// File: rtl/mult_div_unit_pkg.sv
// Shared MD-unit definitions: op codes, operand widths, default latencies and the divider helper.
package mult_div_unit_pkg;

  localparam int unsigned MD_OP_W         = 4;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned DEF_MULT_CYCLES = 5;
  localparam int unsigned DEF_DIV_CYCLES  = 10;

  localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;
  localparam logic [MD_OP_W-1:0] MD_MADD  = 4'd7;
  localparam logic [MD_OP_W-1:0] MD_MADDU = 4'd8;
  localparam logic [MD_OP_W-1:0] MD_MSUB  = 4'd9;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } hilo_t;

  // Sign-magnitude divide: truncates toward zero, remainder takes the dividend sign.
  // Working on magnitudes also makes 0x80000000 / -1 come out as 0x80000000 rem 0.
  function automatic hilo_t div_result(input logic is_signed,
                                       input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] b);
    logic              neg_a;
    logic              neg_b;
    logic [DATA_W-1:0] ma;
    logic [DATA_W-1:0] mb;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] r;
    hilo_t             res;
    neg_a  = is_signed & a[DATA_W-1];
    neg_b  = is_signed & b[DATA_W-1];
    ma     = neg_a ? (~a + DATA_W'(1)) : a;
    mb     = neg_b ? (~b + DATA_W'(1)) : b;
    q      = (mb == '0) ? '0 : ma / mb;
    r      = (mb == '0) ? '0 : ma % mb;
    res.lo = (neg_a ^ neg_b) ? (~q + DATA_W'(1)) : q;
    res.hi = neg_a ? (~r + DATA_W'(1)) : r;
    return res;
  endfunction

endpackage

// File: rtl/mult_div_unit_timer.sv
// Loadable down-counter that times an MD operation; done_c marks the completion edge.
module mult_div_unit_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (load) begin
      busy <= 1'b1;
      cnt  <= count;
    end else if (busy) begin
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - CNT_W'(1);
    end
  end

  assign done_c = busy && (cnt == '0);

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit holding HI/LO. Define MDU_MADD_EN to enable
// the MADD/MADDU/MSUB accumulate ops (codes 7-9); otherwise they decode as NONE.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  output logic               busy,
  output logic [DATA_W-1:0]  hi,
  output logic [DATA_W-1:0]  lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  logic             accept;
  logic             done_c;
  logic             op_long;
  logic             is_div;
  logic             div_signed;
  logic             mul_signed;
  logic             wr_hi;
  logic             wr_lo;
  logic [2*DATA_W-1:0] ext_a;
  logic [2*DATA_W-1:0] ext_b;
  logic [2*DATA_W-1:0] prod;
  hilo_t            quo_rem;
  hilo_t            nxt_pend;
  logic             nxt_we;
  hilo_t            pend;
  logic             pend_we;
`ifdef MDU_MADD_EN
  logic             acc_add;
  logic             acc_sub;
`endif

  assign accept = start && !busy;

  // Op decode
  always_comb begin
    op_long    = 1'b0;
    is_div     = 1'b0;
    div_signed = 1'b0;
    mul_signed = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
`ifdef MDU_MADD_EN
    acc_add    = 1'b0;
    acc_sub    = 1'b0;
`endif
    case (md_op)
      MD_MULT:  begin op_long = 1'b1; mul_signed = 1'b1; end
      MD_MULTU: op_long = 1'b1;
      MD_DIV:   begin op_long = 1'b1; is_div = 1'b1; div_signed = 1'b1; end
      MD_DIVU:  begin op_long = 1'b1; is_div = 1'b1; end
      MD_MTHI:  wr_hi = 1'b1;
      MD_MTLO:  wr_lo = 1'b1;
`ifdef MDU_MADD_EN
      MD_MADD:  begin op_long = 1'b1; mul_signed = 1'b1; acc_add = 1'b1; end
      MD_MADDU: begin op_long = 1'b1; acc_add = 1'b1; end
      MD_MSUB:  begin op_long = 1'b1; mul_signed = 1'b1; acc_sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign ext_a   = {{DATA_W{mul_signed & a[DATA_W-1]}}, a};
  assign ext_b   = {{DATA_W{mul_signed & b[DATA_W-1]}}, b};
  assign prod    = ext_a * ext_b;
  assign quo_rem = div_result(div_signed, a, b);

  // Result captured at accept; a zero divisor suppresses the later write
  always_comb begin
    nxt_pend = hilo_t'(prod);
    nxt_we   = 1'b1;
    if (is_div) begin
      nxt_pend = quo_rem;
      nxt_we   = (b != '0);
    end
`ifdef MDU_MADD_EN
    if (acc_add) nxt_pend = hilo_t'({hi, lo} + prod);
    if (acc_sub) nxt_pend = hilo_t'({hi, lo} - prod);
`endif
  end

  mult_div_unit_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (accept && op_long),
    .count  (is_div ? DIV_LOAD : MULT_LOAD),
    .busy   (busy),
    .done_c (done_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      hi      <= '0;
      lo      <= '0;
      pend    <= '0;
      pend_we <= 1'b0;
    end else begin
      if (accept && op_long) begin
        pend    <= nxt_pend;
        pend_we <= nxt_we;
      end
      if (accept && wr_hi) hi <= a;
      if (accept && wr_lo) lo <= a;
      if (done_c && pend_we) begin
        hi      <= pend.hi;
        lo      <= pend.lo;
        pend_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases with literal expectations plus random traffic
// checked every cycle against an arithmetic model of HI/LO and the busy window.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] a     = 32'd0;
  logic [31:0] b     = 32'd0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int total  = 0;
  int passed = 0;
  bit run    = 1'b0;

  // Model state: remaining busy cycles and the value to commit when they run out
  int          m_left = 0;
  logic [31:0] m_hi   = 32'd0;
  logic [31:0] m_lo   = 32'd0;
  logic [63:0] m_pend = 64'd0;
  bit          m_we   = 1'b0;

  always #5 clk = ~clk;

  mult_div_unit #(
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  always @(posedge clk) begin : model
    longint sa, sb, ua, ub, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    if (reset) begin
      m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_we = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_we) {m_hi, m_lo} = m_pend;
    end else if (start) begin
      case (md_op)
        MD_MULT:  begin m_pend = 64'(sa * sb); m_we = 1'b1; m_left = MC; end
        MD_MULTU: begin m_pend = 64'(ua * ub); m_we = 1'b1; m_left = MC; end
        MD_DIV: begin
          m_we = (b != 32'd0); m_left = DC;
          if (m_we) begin q = sa / sb; r = sa % sb; m_pend = {r[31:0], q[31:0]}; end
        end
        MD_DIVU: begin
          m_we = (b != 32'd0); m_left = DC;
          if (m_we) begin q = ua / ub; r = ua % ub; m_pend = {r[31:0], q[31:0]}; end
        end
        MD_MTHI: m_hi = a;
        MD_MTLO: m_lo = a;
`ifdef MDU_MADD_EN
        MD_MADD:  begin m_pend = {m_hi, m_lo} + 64'(sa * sb); m_we = 1'b1; m_left = MC; end
        MD_MADDU: begin m_pend = {m_hi, m_lo} + 64'(ua * ub); m_we = 1'b1; m_left = MC; end
        MD_MSUB:  begin m_pend = {m_hi, m_lo} - 64'(sa * sb); m_we = 1'b1; m_left = MC; end
`endif
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic tick(input bit st, input logic [3:0] op, input logic [31:0] aa,
                      input logic [31:0] bb, input bit r);
    start = st; md_op = op; a = aa; b = bb; reset = r;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    tick(1'b0, MD_NONE, $urandom, $urandom, 1'b0);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      idle();
      n++;
    end
  endtask

  initial begin
    int n;
    logic [31:0] ra, rb;
    logic [3:0]  rop;
    tick(1'b0, MD_NONE, 32'd0, 32'd0, 1'b1);
    run = 1'b1;
    tick(1'b0, MD_NONE, 32'd0, 32'd0, 1'b1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    tick(1'b1, MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
    chk("mult_busy", 32'(busy), 32'd1);
    chk("mult_hold_hi", hi, 32'd0);
    wait_idle(n);
    chk("mult_cycles", 32'(n), 32'd5);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);

    tick(1'b1, MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    wait_idle(n);
    chk("multu_cycles", 32'(n), 32'd5);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);

    tick(1'b1, MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_idle(n);
    chk("div_cycles", 32'(n), 32'd10);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    tick(1'b1, MD_DIVU, 32'd7, 32'd0, 1'b0);
    wait_idle(n);
    chk("div0_cycles", 32'(n), 32'd10);
    chk("div0_lo", lo, 32'hFFFFFFFD);
    chk("div0_hi", hi, 32'hFFFFFFFF);

    tick(1'b1, MD_MTHI, 32'h12345678, 32'd0, 1'b0);
    chk("mthi_busy", 32'(busy), 32'd0);
    chk("mthi_hi", hi, 32'h12345678);
    tick(1'b1, MD_MTLO, 32'h9ABCDEF0, 32'd0, 1'b0);
    chk("mtlo_busy", 32'(busy), 32'd0);
    chk("mtlo_lo", lo, 32'h9ABCDEF0);
    chk("mtlo_hi", hi, 32'h12345678);

    tick(1'b1, MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_idle(n);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'h00000000);

    tick(1'b1, MD_DIV, 32'd100, 32'd7, 1'b0);
    repeat (3) idle();
    chk("abort_busy_pre", 32'(busy), 32'd1);
    tick(1'b0, MD_NONE, 32'd0, 32'd0, 1'b1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_lo", lo, 32'd0);
    repeat (12) idle();
    chk("abort_late_hi", hi, 32'd0);
    chk("abort_late_lo", lo, 32'd0);

`ifdef MDU_MADD_EN
    tick(1'b1, MD_MTHI, 32'd0, 32'd0, 1'b0);
    tick(1'b1, MD_MTLO, 32'hFFFFFFFF, 32'd0, 1'b0);
    tick(1'b1, MD_MADDU, 32'd1, 32'd1, 1'b0);
    wait_idle(n);
    chk("maddu_cycles", 32'(n), 32'd5);
    chk("maddu_hi", hi, 32'd1);
    chk("maddu_lo", lo, 32'd0);
`else
    tick(1'b1, MD_MTHI, 32'h55, 32'd0, 1'b0);
    tick(1'b1, MD_MTLO, 32'hAA, 32'd0, 1'b0);
    tick(1'b1, MD_MADDU, 32'd1, 32'd1, 1'b0);
    chk("op8_busy", 32'(busy), 32'd0);
    chk("op8_hi", hi, 32'h55);
    chk("op8_lo", lo, 32'hAA);
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        tick(1'b0, MD_NONE, 32'd0, 32'd0, 1'b1);
      end else if (m_left == 0 && $urandom_range(0, 2) != 0) begin
        rop = 4'($urandom_range(0, 15));
        ra  = $urandom;
        rb  = $urandom;
        case ($urandom_range(0, 7))
          0: rb = 32'd0;
          1: rb = 32'hFFFFFFFF;
          2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
          3: rb = 32'($urandom_range(1, 20));
          default: ;
        endcase
        tick(1'b1, rop, ra, rb, 1'b0);
      end else begin
        idle();
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
